// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared state encoding, default widths and helpers
// for the iterative int-to-float converter.
package fpcvt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam int DW_DEF = 12;
  localparam int EW_DEF = 3;
  localparam int FW_DEF = 4;

  // starting exponent: shifts available before the MSB would leave M
  function automatic int e_init(input int dw, input int fw);
    return dw - 1 - fw;
  endfunction

endpackage

// File: rtl/fpcvt_iter_if.sv
// fpcvt_iter_if: sample-in / result-out handshake bundle.
// master = producer/consumer side, slave = converter side.
interface fpcvt_iter_if
  import fpcvt_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int EW = EW_DEF,
  parameter int FW = FW_DEF
);

  logic          in_valid;
  logic [DW-1:0] in_d;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          out_s;
  logic [EW-1:0] out_e;
  logic [FW-1:0] out_f;

  modport master (
    output in_valid, in_d, out_ready,
    input  in_ready, out_valid,
    input  out_s, out_e, out_f
  );

  modport slave (
    input  in_valid, in_d, out_ready,
    output in_ready, out_valid,
    output out_s, out_e, out_f
  );

endinterface

// File: rtl/fpcvt_round.sv
// fpcvt_round: significand rounding and exponent saturation.
// FPCVT_ITER_ROUND_EN selects round-half-up; otherwise truncate.
module fpcvt_round
  import fpcvt_pkg::*;
#(
  parameter int EW = EW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic [FW:0]   m_top,
  input  logic [EW-1:0] e_in,
  output logic [EW-1:0] e_out,
  output logic [FW-1:0] f_out
);

`ifdef FPCVT_ITER_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  logic [FW:0] f_sum;
  logic [EW:0] e_w;
  logic        r;

  // add round bit, renormalise on carry-out, clamp exponent
  always_comb begin
    r     = m_top[0] & RND;
    f_sum = {1'b0, m_top[FW:1]} + {{FW{1'b0}}, r};
    e_w   = {1'b0, e_in};
    f_out = f_sum[FW-1:0];
    if (f_sum[FW]) begin
      f_out = {1'b1, {(FW-1){1'b0}}};
      e_w   = e_w + {{EW{1'b0}}, 1'b1};
    end
    e_out = e_w[EW-1:0];
    if (e_w > {1'b0, {EW{1'b1}}}) begin
      e_out = '1;
      f_out = '1;
    end
  end

endmodule

// File: rtl/fpcvt_iter.sv
// fpcvt_iter: two's-complement to sign/exp/significand, one
// shift per cycle. FPCVT_ITER_ROUND_EN enables rounding.
module fpcvt_iter
  import fpcvt_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int EW = EW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  fpcvt_iter_if.slave bus
);

  if (!((DW - 1 > FW) && (DW - 1 - FW <= (1 << EW) - 1)))
  begin : g_bad_cfg
    $error("fpcvt_iter: illegal DW/EW/FW combination");
  end

  localparam logic [EW-1:0] E0 = EW'(e_init(DW, FW));

  state_t        state;
  logic [DW-2:0] m_q;
  logic [EW-1:0] e_q;
  logic          s_q;
  logic          ov_q;
  logic          os_q;
  logic [EW-1:0] oe_q;
  logic [FW-1:0] of_q;
  logic          accept;
  logic [DW-2:0] mag;
  logic [EW-1:0] r_e;
  logic [FW-1:0] r_f;

  assign bus.in_ready  = (state == IDLE) |
                         ((state == DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = ov_q;
  assign bus.out_s     = os_q;
  assign bus.out_e     = oe_q;
  assign bus.out_f     = of_q;

  // magnitude of the sample; most-negative value saturates
  always_comb begin
    mag = bus.in_d[DW-2:0];
    if (bus.in_d[DW-1]) begin
      mag = ~bus.in_d[DW-2:0] + {{(DW-2){1'b0}}, 1'b1};
      if (bus.in_d[DW-2:0] == '0) mag = '1;
    end
  end

  fpcvt_round #(
    .EW(EW),
    .FW(FW)
  ) u_round (
    .m_top(m_q[DW-2 -: FW+1]),
    .e_in (e_q),
    .e_out(r_e),
    .f_out(r_f)
  );

  // control FSM, normalising shifter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m_q   <= '0;
      e_q   <= '0;
      s_q   <= 1'b0;
      ov_q  <= 1'b0;
      os_q  <= 1'b0;
      oe_q  <= '0;
      of_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) state <= NORM;
        end
        NORM: begin
          if (!m_q[DW-2] && (e_q != '0)) begin
            m_q <= {m_q[DW-3:0], 1'b0};
            e_q <= e_q - {{(EW-1){1'b0}}, 1'b1};
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          os_q  <= s_q;
          oe_q  <= r_e;
          of_q  <= r_f;
          ov_q  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            ov_q  <= 1'b0;
            state <= accept ? NORM : IDLE;
          end
        end
      endcase
      if (accept) begin
        s_q <= bus.in_d[DW-1];
        m_q <= mag;
        e_q <= E0;
      end
    end
  end

endmodule

// File: tb/tb_fpcvt_iter.sv
// tb_fpcvt_iter: directed vectors against an arithmetic model
// of the conversion, checked every cycle a result is shown.
module tb_fpcvt_iter;

  localparam int DW = 12;
  localparam int EW = 3;
  localparam int FW = 4;

  typedef struct {
    logic s;
    int   e;
    int   f;
    int   lat;
    int   acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  bit   shown = 1'b0;
  exp_t q[$];
  exp_t xm;
  int   waits;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpcvt_iter_if #(.DW(DW), .EW(EW), .FW(FW)) bus ();

  fpcvt_iter #(.DW(DW), .EW(EW), .FW(FW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  // value = f * 2^e, f normalised to FW bits where magnitude allows
  function automatic exp_t model(input logic [DW-1:0] d);
    exp_t x;
    int sv, mag, p, e0, k;
    sv = int'(d);
    if (d[DW-1]) sv = sv - (1 << DW);
    mag = (sv < 0) ? -sv : sv;
    if (mag > (1 << (DW-1)) - 1) mag = (1 << (DW-1)) - 1;
    p = -1;
    for (int i = 0; i < DW-1; i++)
      if (((mag >> i) & 1) != 0) p = i;
    e0 = DW - 1 - FW;
    k  = (p < 0) ? e0 : DW - 2 - p;
    if (k > e0) k = e0;
    x.e = e0 - k;
    x.f = mag >> x.e;
`ifdef FPCVT_ITER_ROUND_EN
    begin
      int r;
      r = (x.e > 0) ? ((mag >> (x.e - 1)) & 1) : 0;
      x.f = x.f + r;
      if (x.f == (1 << FW)) begin
        x.f = 1 << (FW-1);
        x.e = x.e + 1;
      end
    end
`endif
    if (x.e > (1 << EW) - 1) begin
      x.e = (1 << EW) - 1;
      x.f = (1 << FW) - 1;
    end
    x.s   = d[DW-1];
    x.lat = k + 2;
    x.acc = 0;
    return x;
  endfunction

  function automatic int pk(input int s, input int e,
                            input int f, input int lat);
    return s * 4096 + e * 256 + f * 16 + lat;
  endfunction

  function automatic int pkm(input logic [DW-1:0] d);
    exp_t x;
    x = model(d);
    return pk(int'(x.s), x.e, x.f, x.lat);
  endfunction

  // compare process: every cycle a result is on the outputs
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      shown = 1'b0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", bus.out_valid, 0);
        end else begin
          if (!shown) begin
            chk("latency", cyc - q[0].acc, q[0].lat);
            shown = 1'b1;
          end
          chk("result", {bus.out_s, bus.out_e, bus.out_f},
              (int'(q[0].s) << (EW+FW)) | (q[0].e << FW) | q[0].f);
          if (bus.out_ready) begin
            void'(q.pop_front());
            shown = 1'b0;
          end
        end
      end else if (shown) begin
        chk("valid_dropped", bus.out_valid, 1);
      end
      if (bus.in_valid && bus.in_ready) begin
        xm = model(bus.in_d);
        xm.acc = cyc + 1;
        q.push_back(xm);
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, output int n);
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_d     = d;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_d     = DW'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] vecs [11] = '{
    12'h0AA, 12'hFFF, 12'h800, 12'h01F, 12'h000, 12'h7FF,
    12'h001, 12'h400, 12'h123, 12'hC01, 12'h008
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_d      = '0;
    bus.out_ready = 1'b1;

`ifdef FPCVT_ITER_ROUND_EN
    chk("pin_0AA", pkm(12'h0AA), pk(0, 4, 11, 5));
    chk("pin_01F", pkm(12'h01F), pk(0, 2, 8, 8));
    chk("pin_02F", pkm(12'h02F), pk(0, 2, 12, 7));
`else
    chk("pin_0AA", pkm(12'h0AA), pk(0, 4, 10, 5));
    chk("pin_01F", pkm(12'h01F), pk(0, 1, 15, 8));
    chk("pin_02F", pkm(12'h02F), pk(0, 2, 11, 7));
`endif
    chk("pin_FFF", pkm(12'hFFF), pk(1, 0, 1, 9));
    chk("pin_800", pkm(12'h800), pk(1, 7, 15, 2));
    chk("pin_A44", pkm(12'hA44), pk(1, 7, 11, 2));
    chk("pin_000", pkm(12'h000), pk(0, 0, 0, 9));

    repeat (3) @(negedge clk);
    chk("rst_outs", {bus.out_s, bus.out_e, bus.out_f}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      send(vecs[i], waits);
      drain();
    end

    bus.out_ready = 1'b0;
    send(12'hA44, waits);
    repeat (12) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(12'h02F, waits);
    chk("b2b_accept_wait", waits, 0);
    drain();

    send(12'hFFF, waits);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_ready", bus.in_ready, 1);
    chk("async_rst_outs", {bus.out_s, bus.out_e, bus.out_f}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_idle", {bus.out_valid, bus.in_ready}, 1);
    end
    @(posedge clk);
    #1;
    send(12'h000, waits);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fpcvt_iter.md
FPCVT_ITER -- requirements
Module: fpcvt_iter

Interface
REQ-001 Parameter DW, default 12: input two's-complement width.
REQ-002 Parameter EW, default 3: exponent width.
REQ-003 Parameter FW, default 4: significand width. Legal only when DW-1 > FW and DW-1-FW <= 2^EW-1; elaboration SHALL fail otherwise.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  in_d carries a sample.
REQ-007 in_d  input  DW  two's-complement sample.
REQ-008 in_ready  output  1  block accepts in_d this cycle.
REQ-009 out_valid  output  1  out_s/out_e/out_f hold a result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_s  output  1  sign, 1 = negative.
REQ-012 out_e  output  EW  exponent.
REQ-013 out_f  output  FW  significand; represented value = out_f * 2^out_e.

Function
REQ-014 States SHALL be IDLE, NORM, ROUND and DONE.
REQ-015 Accept: in_valid && in_ready; in_ready SHALL be 1 in IDLE, or in DONE when out_ready=1; 0 otherwise.
REQ-016 On accept, capture S = in_d[DW-1] and M = |in_d| (DW-1 bits), set E = DW-1-FW, go to NORM.
REQ-017 Magnitude of -2^(DW-1) SHALL saturate to 2^(DW-1)-1.
REQ-018 NORM, each cycle: if M[DW-2]=0 and E>0, shift M left 1 and decrement E; otherwise go to ROUND. One shift per cycle.
REQ-019 ROUND: F = M[DW-2 -: FW], R = M[DW-2-FW].
REQ-020 If R=1 and F is all-ones, SHALL set F = 2^(FW-1) and increment E; otherwise F = F+R.
REQ-021 If E would exceed 2^EW-1, SHALL set E = 2^EW-1 and F = all-ones (saturation).
REQ-022 ROUND SHALL register out_s/out_e/out_f and go to DONE.
REQ-023 Latency: out_valid SHALL rise k+2 cycles after the accepting edge, k = shifts performed (0..DW-1-FW).
REQ-024 In DONE, out_valid=1; outputs SHALL stay stable while out_ready=0.
REQ-025 DONE with out_ready=1: without in_valid, go to IDLE; with in_valid, accept the new sample in the same cycle and go to NORM (back-to-back).
REQ-026 Zero input SHALL yield S=0, E=0, F=0 after DW-1-FW shifts.
REQ-027 in_d and in_valid SHALL be ignored outside accept cycles.

Reset
REQ-028 rst SHALL force IDLE, out_valid=0, out_s=0, out_e=0, out_f=0, and clear internal M/E, immediately and regardless of state.
REQ-029 A conversion in flight at reset SHALL be discarded, with no output produced.
REQ-030 in_ready SHALL read 1 during and after reset.

Configuration
REQ-031 Macro FPCVT_ITER_ROUND_EN defined: rounding per REQ-020/021 (round-half-up on R).
REQ-032 Macro undefined: R SHALL be ignored (truncation); saturation applies only to E; latency unchanged.

Structure
REQ-033 Package fpcvt_pkg SHALL hold the state enumeration, default DW/EW/FW constants, and a function returning DW-1-FW.
REQ-034 Rounding/saturation (REQ-019..021, REQ-031/032) SHALL be a combinational sub-module fpcvt_round; the FSM and shifter stay in fpcvt_iter.

Verification (defaults DW=12, EW=3, FW=4, macro defined unless stated)
REQ-035 in_d=0x0AA -> S=0, E=4, F=1011 (176); out_valid 5 cycles after accept; without macro F=1010.
REQ-036 in_d=0xFFF -> S=1, E=0, F=0001; 9-cycle latency (7 shifts, E clamps at 0).
REQ-037 in_d=0x800 -> S=1, E=7, F=1111 (saturation); 2-cycle latency. in_d=0x01F -> S=0, E=2, F=1000 (significand overflow).
REQ-038 in_d=0xA44 with out_ready=0 for 10 cycles -> S=1, E=7, F=1011 held stable; then out_ready=1 with in_valid, in_d=0x02F -> back-to-back accept, next result E=2, F=1100.
REQ-039 rst pulsed during NORM of 0xFFF -> out_valid stays 0, state IDLE, in_ready=1; next in_d=0x000 -> S=0, E=0, F=0000.
